// File: rtl/regfile_psr_if.sv
// Operand/writeback bus between decode/ALU and the register file + PSR block.
// The slave side is the register file; the master side is decode and the ALU.
interface regfile_psr_if #(
  parameter int DATA_WIDTH = 16
);
  logic [3:0]            I_RA_ADDR;
  logic [3:0]            I_RB_ADDR;
  logic [DATA_WIDTH-1:0] O_RA_DATA;
  logic [DATA_WIDTH-1:0] O_RB_DATA;
  logic                  I_WR_EN;
  logic [3:0]            I_WR_ADDR;
  logic [DATA_WIDTH-1:0] I_WR_DATA;
  logic                  I_PSR_WR_EN;
  logic [4:0]            I_PSR_MASK;
  logic [4:0]            I_STATUS;
  logic [4:0]            O_PSR;
  logic [3:0]            I_COND;
  logic                  O_COND_TRUE;

  modport slave (
    input  I_RA_ADDR, I_RB_ADDR, I_WR_EN, I_WR_ADDR, I_WR_DATA,
    input  I_PSR_WR_EN, I_PSR_MASK, I_STATUS, I_COND,
    output O_RA_DATA, O_RB_DATA, O_PSR, O_COND_TRUE
  );

  modport master (
    output I_RA_ADDR, I_RB_ADDR, I_WR_EN, I_WR_ADDR, I_WR_DATA,
    output I_PSR_WR_EN, I_PSR_MASK, I_STATUS, I_COND,
    input  O_RA_DATA, O_RB_DATA, O_PSR, O_COND_TRUE
  );
endinterface

// File: rtl/regfile_psr.sv
// CR16 operand/writeback stage: 2R1W register file with write-through bypass,
// masked PSR latch and branch/Scond condition evaluation on the registered PSR.
module regfile_psr #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16
) (
  input  logic           I_CLK,
  input  logic           I_NRESET,
  regfile_psr_if.slave   bus
);

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  logic [DATA_WIDTH-1:0] reg_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] reg_d [REG_COUNT];
  logic [4:0]            psr_q;
  logic [4:0]            psr_d;

  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] ra_data;
  logic [DATA_WIDTH-1:0] rb_data;
  logic                  cond_true;

  assign wr_hit = bus.I_WR_EN && (int'(bus.I_WR_ADDR) < REG_COUNT);

  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      reg_d[i] = reg_q[i];
      if (wr_hit && (int'(bus.I_WR_ADDR) == i)) begin
        reg_d[i] = bus.I_WR_DATA;
      end
    end
  end

  always_comb begin
    psr_d = psr_q;
    if (bus.I_PSR_WR_EN) begin
      psr_d = (psr_q & ~bus.I_PSR_MASK) | (bus.I_STATUS & bus.I_PSR_MASK);
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        reg_q[i] <= '0;
      end
      psr_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        reg_q[i] <= reg_d[i];
      end
      psr_q <= psr_d;
    end
  end

  // Bypass lets a dependent op read the value being written this cycle.
  always_comb begin
    ra_data = '0;
    if (int'(bus.I_RA_ADDR) < REG_COUNT) begin
      ra_data = reg_q[bus.I_RA_ADDR];
    end
    if (bus.I_WR_EN && (bus.I_WR_ADDR == bus.I_RA_ADDR)) begin
      ra_data = bus.I_WR_DATA;
    end
  end

  always_comb begin
    rb_data = '0;
    if (int'(bus.I_RB_ADDR) < REG_COUNT) begin
      rb_data = reg_q[bus.I_RB_ADDR];
    end
    if (bus.I_WR_EN && (bus.I_WR_ADDR == bus.I_RB_ADDR)) begin
      rb_data = bus.I_WR_DATA;
    end
  end

  // Conditions see only the latched PSR, never the incoming status.
  always_comb begin
    cond_true = 1'b0;
    case (bus.I_COND)
      4'd0:  cond_true =  psr_q[PSR_Z];
      4'd1:  cond_true = !psr_q[PSR_Z];
      4'd2:  cond_true =  psr_q[PSR_C];
      4'd3:  cond_true = !psr_q[PSR_C];
      4'd4:  cond_true =  psr_q[PSR_L];
      4'd5:  cond_true = !psr_q[PSR_L];
      4'd6:  cond_true =  psr_q[PSR_N];
      4'd7:  cond_true = !psr_q[PSR_N];
      4'd8:  cond_true =  psr_q[PSR_F];
      4'd9:  cond_true = !psr_q[PSR_F];
      4'd10: cond_true = !psr_q[PSR_L] && !psr_q[PSR_Z];
      4'd11: cond_true =  psr_q[PSR_L] ||  psr_q[PSR_Z];
      4'd12: cond_true = !psr_q[PSR_N] && !psr_q[PSR_Z];
      4'd13: cond_true =  psr_q[PSR_N] ||  psr_q[PSR_Z];
      4'd14: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign bus.O_RA_DATA   = ra_data;
  assign bus.O_RB_DATA   = rb_data;
  assign bus.O_PSR       = psr_q;
  assign bus.O_COND_TRUE = cond_true;

endmodule

// File: tb/tb_regfile_psr.sv
// Bench for regfile_psr: directed vector table, condition sweep, ALU loop,
// and randomized traffic against an array/flag-level reference model.
module tb_regfile_psr;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  logic [15:0] mdl_mem [16];
  logic [4:0]  mdl_psr;

  regfile_psr_if #(.DATA_WIDTH(16)) bus ();

  regfile_psr #(.DATA_WIDTH(16), .REG_COUNT(16)) dut (
    .I_CLK    (clk),
    .I_NRESET (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        psr_en;
    logic [4:0]  mask;
    logic [4:0]  status;
    logic [3:0]  cond;
    logic [15:0] exp_ra;
    logic [15:0] exp_rb;
    logic [4:0]  exp_psr;
    logic        exp_cond;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cond_model(input logic [3:0] code, input logic [4:0] p);
    logic c, l, f, z, n;
    {n, z, f, l, c} = p;
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Minimal ALU: op 0 = ADD a+b, op 1 = SUB/compare b-a. Status {N,Z,F,L,C}.
  task automatic alu(input int op, input logic [15:0] a, input logic [15:0] b,
                     output logic [15:0] res, output logic [4:0] st);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 0) begin
      res = a + b;
      sr  = sa + sb;
      st  = {1'b0, (res == 16'h0), (sr > 32767 || sr < -32768), 1'b0,
             ((int'(a) + int'(b)) > 65535)};
    end else begin
      res = b - a;
      sr  = sb - sa;
      st  = {(sb > sa), (a == b), (sr > 32767 || sr < -32768), (b > a), (a > b)};
    end
  endtask

  function automatic logic [15:0] mdl_read(input logic [3:0] addr);
    if (bus.I_WR_EN && bus.I_WR_ADDR == addr) return bus.I_WR_DATA;
    return mdl_mem[addr];
  endfunction

  task automatic idle();
    bus.I_RA_ADDR   = '0;
    bus.I_RB_ADDR   = '0;
    bus.I_WR_EN     = 1'b0;
    bus.I_WR_ADDR   = '0;
    bus.I_WR_DATA   = '0;
    bus.I_PSR_WR_EN = 1'b0;
    bus.I_PSR_MASK  = '0;
    bus.I_STATUS    = '0;
    bus.I_COND      = '0;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    mdl_psr = '0;
  endtask

  // Clock edge, then fold the driven inputs into the model.
  task automatic step();
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        pe;
    logic [4:0]  pm;
    logic [4:0]  ps;
    we = bus.I_WR_EN; wa = bus.I_WR_ADDR; wd = bus.I_WR_DATA;
    pe = bus.I_PSR_WR_EN; pm = bus.I_PSR_MASK; ps = bus.I_STATUS;
    @(posedge clk);
    #1;
    if (we) mdl_mem[wa] = wd;
    if (pe) for (int n = 0; n < 5; n++) if (pm[n]) mdl_psr[n] = ps[n];
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    idle();
    bus.I_WR_EN = 1'b1; bus.I_WR_ADDR = a; bus.I_WR_DATA = d;
    step();
    idle();
  endtask

  initial begin
    logic [15:0] res;
    logic [4:0]  st;
    n_checks = 0;
    n_fails  = 0;
    idle();
    mdl_reset();
    rst_n = 1'b0;
    #2;
    chk("reset_psr", 32'(bus.O_PSR), 32'h0);
    chk("reset_ra", 32'(bus.O_RA_DATA), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset clears a freshly written register.
    write_reg(4'd5, 16'hBEEF);
    bus.I_RA_ADDR = 4'd5;
    #1 chk("pre_reset_r5", 32'(bus.O_RA_DATA), 32'hBEEF);
    #1 rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("async_reset_r5", 32'(bus.O_RA_DATA), 32'h0);
    chk("async_reset_psr", 32'(bus.O_PSR), 32'h0);
    bus.I_COND = 4'd14;
    #1 chk("reset_cond_uc", 32'(bus.O_COND_TRUE), 32'h1);
    bus.I_COND = 4'd15;
    #1 chk("reset_cond_never", 32'(bus.O_COND_TRUE), 32'h0);
    rst_n = 1'b1;
    step();

    vecs[0]  = '{1'b1, 4'd3,  16'h1234, 4'd3,  4'd12, 1'b0, 5'b00000, 5'b00000, 4'd14, 16'h1234, 16'h0000, 5'b00000, 1'b1};
    vecs[1]  = '{1'b1, 4'd12, 16'hFFFF, 4'd3,  4'd12, 1'b0, 5'b00000, 5'b00000, 4'd15, 16'h1234, 16'hFFFF, 5'b00000, 1'b0};
    vecs[2]  = '{1'b1, 4'd7,  16'h0001, 4'd0,  4'd5,  1'b1, 5'b01001, 5'b11111, 4'd0,  16'h0000, 16'h0000, 5'b00000, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd12, 1'b0, 5'b11111, 5'b00000, 4'd0,  16'h1234, 16'hFFFF, 5'b01001, 1'b1};
    vecs[4]  = '{1'b1, 4'd7,  16'hA5A5, 4'd7,  4'd7,  1'b1, 5'b11111, 5'b10010, 4'd2,  16'hA5A5, 16'hA5A5, 5'b01001, 1'b1};
    vecs[5]  = '{1'b0, 4'd0,  16'h0000, 4'd7,  4'd7,  1'b0, 5'b00000, 5'b00000, 4'd6,  16'hA5A5, 16'hA5A5, 5'b10010, 1'b1};
    vecs[6]  = '{1'b0, 4'd0,  16'h0000, 4'd1,  4'd2,  1'b0, 5'b00000, 5'b00000, 4'd12, 16'h0000, 16'h0000, 5'b10010, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  16'h0000, 4'd12, 4'd3,  1'b0, 5'b00000, 5'b00000, 4'd10, 16'hFFFF, 16'h1234, 5'b10010, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  16'h0000, 4'd7,  4'd0,  1'b0, 5'b00000, 5'b00000, 4'd13, 16'hA5A5, 16'h0000, 5'b10010, 1'b1};
    vecs[9]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd6,  1'b0, 5'b00000, 5'b00000, 4'd11, 16'h0000, 16'h0000, 5'b10010, 1'b1};
    vecs[10] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd14, 1'b0, 5'b00000, 5'b00000, 4'd0,  16'h0000, 16'h0000, 5'b10010, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  16'h0000, 4'd12, 4'd12, 1'b0, 5'b00000, 5'b00000, 4'd4,  16'hFFFF, 16'hFFFF, 5'b10010, 1'b1};

    for (int v = 0; v < 12; v++) begin
      bus.I_WR_EN     = vecs[v].wr_en;
      bus.I_WR_ADDR   = vecs[v].wr_addr;
      bus.I_WR_DATA   = vecs[v].wr_data;
      bus.I_RA_ADDR   = vecs[v].ra;
      bus.I_RB_ADDR   = vecs[v].rb;
      bus.I_PSR_WR_EN = vecs[v].psr_en;
      bus.I_PSR_MASK  = vecs[v].mask;
      bus.I_STATUS    = vecs[v].status;
      bus.I_COND      = vecs[v].cond;
      #1;
      chk($sformatf("vec%0d_ra", v), 32'(bus.O_RA_DATA), 32'(vecs[v].exp_ra));
      chk($sformatf("vec%0d_rb", v), 32'(bus.O_RB_DATA), 32'(vecs[v].exp_rb));
      chk($sformatf("vec%0d_psr", v), 32'(bus.O_PSR), 32'(vecs[v].exp_psr));
      chk($sformatf("vec%0d_cond", v), 32'(bus.O_COND_TRUE), 32'(vecs[v].exp_cond));
      step();
    end
    idle();

    for (int r = 0; r < 16; r++) begin
      bus.I_RA_ADDR = 4'(r);
      bus.I_RB_ADDR = 4'(15 - r);
      #1;
      chk($sformatf("dump_ra_r%0d", r), 32'(bus.O_RA_DATA), 32'(mdl_mem[r]));
      chk($sformatf("dump_rb_r%0d", 15 - r), 32'(bus.O_RB_DATA), 32'(mdl_mem[15 - r]));
    end

    for (int p = 0; p < 32; p++) begin
      idle();
      bus.I_PSR_WR_EN = 1'b1; bus.I_PSR_MASK = 5'h1F; bus.I_STATUS = 5'(p);
      step();
      idle();
      chk($sformatf("sweep_psr_%0d", p), 32'(bus.O_PSR), 32'(p));
      for (int c = 0; c < 16; c++) begin
        bus.I_COND = 4'(c);
        #1;
        chk($sformatf("sweep_p%0d_c%0d", p, c), 32'(bus.O_COND_TRUE),
            32'(cond_model(4'(c), 5'(p))));
      end
    end

    // ALU closed loop: r3 = r1 + r2, then dependent compare reads r3.
    write_reg(4'd1, 16'd7);
    write_reg(4'd2, 16'd9);
    bus.I_RA_ADDR = 4'd1; bus.I_RB_ADDR = 4'd2;
    #1;
    alu(0, bus.O_RA_DATA, bus.O_RB_DATA, res, st);
    bus.I_WR_EN = 1'b1; bus.I_WR_ADDR = 4'd3; bus.I_WR_DATA = res;
    bus.I_PSR_WR_EN = 1'b1; bus.I_PSR_MASK = 5'h1F; bus.I_STATUS = st;
    #1 chk("loop_add_bypass", 32'(bus.O_RA_DATA), 32'd7);
    step();
    idle();
    bus.I_RA_ADDR = 4'd3; bus.I_RB_ADDR = 4'd1;
    #1;
    chk("loop_r3", 32'(bus.O_RA_DATA), 32'h0010);
    chk("loop_z", 32'(bus.O_PSR[3]), 32'h0);
    chk("loop_psr_model", 32'(bus.O_PSR), 32'(mdl_psr));
    write_reg(4'd4, 16'd3);
    write_reg(4'd5, 16'd5);
    bus.I_RA_ADDR = 4'd4; bus.I_RB_ADDR = 4'd5;
    #1;
    alu(1, bus.O_RA_DATA, bus.O_RB_DATA, res, st);
    bus.I_PSR_WR_EN = 1'b1; bus.I_PSR_MASK = 5'h1F; bus.I_STATUS = st;
    step();
    idle();
    chk("sub_psr", 32'(bus.O_PSR), 32'(5'b10010));
    for (int k = 0; k < 7; k++) begin
      bus.I_COND = (k == 0) ? 4'd6 : (k == 1) ? 4'd4 : (k == 2) ? 4'd13 :
                   (k == 3) ? 4'd11 : (k == 4) ? 4'd0 : (k == 5) ? 4'd12 : 4'd10;
      #1 chk($sformatf("sub_cond_%0d", bus.I_COND), 32'(bus.O_COND_TRUE), 32'(k < 4));
    end

    for (int t = 0; t < 400; t++) begin
      bus.I_WR_EN     = 1'($urandom_range(0, 1));
      bus.I_WR_ADDR   = 4'($urandom);
      bus.I_WR_DATA   = 16'($urandom);
      bus.I_RA_ADDR   = ($urandom_range(0, 3) == 0) ? bus.I_WR_ADDR : 4'($urandom);
      bus.I_RB_ADDR   = ($urandom_range(0, 3) == 0) ? bus.I_WR_ADDR : 4'($urandom);
      bus.I_PSR_WR_EN = 1'($urandom_range(0, 1));
      bus.I_PSR_MASK  = 5'($urandom);
      bus.I_STATUS    = 5'($urandom);
      bus.I_COND      = 4'($urandom);
      #1;
      chk("rand_ra", 32'(bus.O_RA_DATA), 32'(mdl_read(bus.I_RA_ADDR)));
      chk("rand_rb", 32'(bus.O_RB_DATA), 32'(mdl_read(bus.I_RB_ADDR)));
      chk("rand_psr", 32'(bus.O_PSR), 32'(mdl_psr));
      chk("rand_cond", 32'(bus.O_COND_TRUE), 32'(cond_model(bus.I_COND, mdl_psr)));
      step();
    end

    // Reset held across an edge with a write pending: no write may land.
    idle();
    bus.I_WR_EN = 1'b1; bus.I_WR_ADDR = 4'd9; bus.I_WR_DATA = 16'h5555;
    bus.I_PSR_WR_EN = 1'b1; bus.I_PSR_MASK = 5'h1F; bus.I_STATUS = 5'h1F;
    rst_n = 1'b0;
    @(posedge clk); #1;
    idle();
    mdl_reset();
    rst_n = 1'b1;
    bus.I_RA_ADDR = 4'd9; bus.I_RB_ADDR = 4'd12;
    #1;
    chk("rst_vs_write_r9", 32'(bus.O_RA_DATA), 32'h0);
    chk("rst_vs_write_r12", 32'(bus.O_RB_DATA), 32'h0);
    chk("rst_vs_write_psr", 32'(bus.O_PSR), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
